// File: rtl/fx3_thread_arbiter.sv
// FX3 slave-FIFO control plane: shares the GPIF bus between the download (thread 3)
// and upload (thread 0) requesters and drives thread address, strobes and grants.
module fx3_thread_arbiter #(
    parameter int unsigned PKT_BYTES  = 512,
    parameter int unsigned SWITCH_DLY = 3,
    parameter int unsigned FLAG_LAT   = 2,
    parameter int unsigned COMMIT_GAP = 4
) (
    input  logic        fx3_clk,
    input  logic        fx3_rst,
    input  logic        frame_rst_fx3,
    input  logic        dl_req,
    input  logic        ul_req,
    input  logic        ul_vld,
    input  logic        fx3_flaga,
    output logic [1:0]  fx3_a,
    output logic        fx3_slrd_n,
    output logic        fx3_slwr_n,
    output logic        fx3_pktend_n,
    output logic        dl_grant,
    output logic        ul_grant,
    output logic        ul_ready,
    output logic [15:0] ul_pkt_cnt
);
    localparam int unsigned CW   = $clog2(PKT_BYTES);
    localparam int unsigned T1   = (SWITCH_DLY > FLAG_LAT) ? SWITCH_DLY : FLAG_LAT;
    localparam int unsigned TMAX = (T1 > COMMIT_GAP) ? T1 : COMMIT_GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [1:0]  A_DL = 2'b11;
    localparam logic [1:0]  A_UL = 2'b00;

    typedef enum logic [2:0] {
        IDLE, SWITCH, DL_BURST, DL_DRAIN, UL_BURST, UL_COMMIT
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
    logic [FLAG_LAT-1:0] flag_pipe;
    logic            flag_q;
    logic            pend_ul, pend_ul_nxt;
    logic            last_dl, last_dl_nxt;
    logic            win_ul, ul_wr;
    logic [1:0]      win_a, fx3_a_nxt;
    logic            pktend_n_nxt;

    // Clearing the pipe in SWITCH also blanks flag_q for FLAG_LAT cycles after exit.
    assign flag_q = flag_pipe[FLAG_LAT-1] & (state != SWITCH);
    assign win_ul = ul_req & (~dl_req | last_dl);
    assign win_a  = win_ul ? A_UL : A_DL;
    assign ul_wr  = (state == UL_BURST) & ul_vld & ul_ready;

    always_comb begin
        state_nxt    = state;
        pend_ul_nxt  = pend_ul;
        last_dl_nxt  = last_dl;
        byte_cnt_nxt = byte_cnt;
        fx3_a_nxt    = fx3_a;
        pktend_n_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (dl_req || ul_req) begin
                    if (win_a != fx3_a) begin
                        fx3_a_nxt   = win_a;
                        pend_ul_nxt = win_ul;
                        state_nxt   = SWITCH;
                    end else begin
                        state_nxt = win_ul ? UL_BURST : DL_BURST;
                    end
                end
            end
            SWITCH: begin
                if (pend_ul ? !ul_req : !dl_req)
                    state_nxt = IDLE;
                else if (tmr == TW'(SWITCH_DLY - 1))
                    state_nxt = pend_ul ? UL_BURST : DL_BURST;
            end
            DL_BURST: begin
                // flag_q is not trusted until the pipe has refilled after entry.
                if (!dl_req || (!flag_q && tmr >= TW'(FLAG_LAT)))
                    state_nxt = DL_DRAIN;
            end
            DL_DRAIN: begin
                if (tmr == TW'(FLAG_LAT - 1)) begin
                    state_nxt   = IDLE;
                    last_dl_nxt = 1'b1;
                end
            end
            UL_BURST: begin
                if (ul_wr) begin
                    byte_cnt_nxt = byte_cnt + CW'(1);
                    if (byte_cnt == CW'(PKT_BYTES - 1))
                        state_nxt = UL_COMMIT;
                end else if (!ul_req) begin
                    if (byte_cnt != '0) begin
                        pktend_n_nxt = 1'b0;
                        byte_cnt_nxt = '0;
                        state_nxt    = UL_COMMIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            UL_COMMIT: begin
                if (tmr == TW'(COMMIT_GAP - 1)) begin
                    state_nxt   = IDLE;
                    last_dl_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state)
            tmr_nxt = '0;
        else if (tmr != TW'(TMAX))
            tmr_nxt = tmr + TW'(1);
        else
            tmr_nxt = tmr;
    end

    always_ff @(posedge fx3_clk or posedge fx3_rst) begin
        if (fx3_rst) begin
            state        <= IDLE;
            tmr          <= '0;
            byte_cnt     <= '0;
            flag_pipe    <= '0;
            pend_ul      <= 1'b0;
            last_dl      <= 1'b0;
            fx3_a        <= A_DL;
            fx3_slrd_n   <= 1'b1;
            fx3_slwr_n   <= 1'b1;
            fx3_pktend_n <= 1'b1;
            dl_grant     <= 1'b0;
            ul_grant     <= 1'b0;
            ul_ready     <= 1'b0;
            ul_pkt_cnt   <= '0;
        end else if (frame_rst_fx3) begin
            state        <= IDLE;
            tmr          <= '0;
            byte_cnt     <= '0;
            flag_pipe    <= '0;
            pend_ul      <= 1'b0;
            last_dl      <= 1'b0;
            fx3_a        <= A_DL;
            fx3_slrd_n   <= 1'b1;
            fx3_slwr_n   <= 1'b1;
            fx3_pktend_n <= 1'b1;
            dl_grant     <= 1'b0;
            ul_grant     <= 1'b0;
            ul_ready     <= 1'b0;
            ul_pkt_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            byte_cnt <= byte_cnt_nxt;
            pend_ul  <= pend_ul_nxt;
            last_dl  <= last_dl_nxt;
            if (state == SWITCH) begin
                flag_pipe <= '0;
            end else begin
                for (int unsigned i = 1; i < FLAG_LAT; i++)
                    flag_pipe[i] <= flag_pipe[i-1];
                flag_pipe[0] <= fx3_flaga;
            end
            fx3_a        <= fx3_a_nxt;
            fx3_slrd_n   <= ~((state == DL_BURST) & flag_q & dl_req);
            fx3_slwr_n   <= ~ul_wr;
            fx3_pktend_n <= pktend_n_nxt;
            dl_grant     <= (state_nxt == DL_BURST) || (state_nxt == DL_DRAIN);
            ul_grant     <= (state_nxt == UL_BURST) || (state_nxt == UL_COMMIT);
            ul_ready     <= (state_nxt == UL_BURST) & flag_q;
            if (state != UL_COMMIT && state_nxt == UL_COMMIT)
                ul_pkt_cnt <= ul_pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fx3_thread_arbiter.sv
// Directed bench for fx3_thread_arbiter: thread switching, DL/UL bursts, packet
// boundaries, short-packet end, round-robin, flag stalls and both resets.
module tb_fx3_thread_arbiter;
    logic        fx3_clk = 1'b0;
    logic        fx3_rst = 1'b1;
    logic        frame_rst_fx3 = 1'b0;
    logic        dl_req = 1'b0;
    logic        ul_req = 1'b0;
    logic        ul_vld = 1'b0;
    logic        fx3_flaga = 1'b0;
    logic [1:0]  fx3_a;
    logic        fx3_slrd_n, fx3_slwr_n, fx3_pktend_n;
    logic        dl_grant, ul_grant, ul_ready;
    logic [15:0] ul_pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    fx3_thread_arbiter #(
        .PKT_BYTES(512), .SWITCH_DLY(3), .FLAG_LAT(2), .COMMIT_GAP(4)
    ) dut (
        .fx3_clk(fx3_clk), .fx3_rst(fx3_rst), .frame_rst_fx3(frame_rst_fx3),
        .dl_req(dl_req), .ul_req(ul_req), .ul_vld(ul_vld), .fx3_flaga(fx3_flaga),
        .fx3_a(fx3_a), .fx3_slrd_n(fx3_slrd_n), .fx3_slwr_n(fx3_slwr_n),
        .fx3_pktend_n(fx3_pktend_n), .dl_grant(dl_grant), .ul_grant(ul_grant),
        .ul_ready(ul_ready), .ul_pkt_cnt(ul_pkt_cnt)
    );

    always #5 fx3_clk = ~fx3_clk;

    task automatic tick();
        @(posedge fx3_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents up to n bytes, only while ul_ready is seen high; counts strobes seen.
    task automatic ul_send(input int n, output int nw, output int npe);
        int nv;
        nv = 0; nw = 0; npe = 0;
        for (int c = 0; c < 4 * n + 50 && nw < n; c++) begin
            ul_vld = ul_ready && (nv < n);
            if (ul_vld) nv++;
            tick();
            if (!fx3_slwr_n) nw++;
            if (!fx3_pktend_n) npe++;
        end
        ul_vld = 1'b0;
    endtask

    initial begin
        int nw, npe, nw2, npe2, rz, sw, dl_reads, nstart, gap, overlap, found;
        logic [1:0] seq [3];
        logic [1:0] a_at [3];
        int gaps [3];
        logic dl_avail, prev_any;

        // ---- reset state
        tick(); tick();
        chk("rst_a", 32'(fx3_a), 32'd3);
        chk("rst_strobes", 32'({fx3_slrd_n, fx3_slwr_n, fx3_pktend_n}), 32'b111);
        chk("rst_grants", 32'({dl_grant, ul_grant, ul_ready}), 32'b000);
        chk("rst_pktcnt", 32'(ul_pkt_cnt), 32'd0);
        fx3_rst = 1'b0;
        tick();

        // ---- same-thread download: no switch, slrd_n low on third edge
        dl_req = 1'b1; fx3_flaga = 1'b1;
        tick();
        chk("dl_grant0", 32'(dl_grant), 32'd1);
        chk("dl_a_kept", 32'(fx3_a), 32'd3);
        chk("dl_slrd_e0", 32'(fx3_slrd_n), 32'd1);
        tick();
        chk("dl_slrd_e1", 32'(fx3_slrd_n), 32'd1);
        tick();
        chk("dl_slrd_e2", 32'(fx3_slrd_n), 32'd0);
        tick();
        fx3_flaga = 1'b0;
        tick();
        chk("dl_slrd_fq1", 32'(fx3_slrd_n), 32'd0);
        tick();
        chk("dl_slrd_fq2", 32'(fx3_slrd_n), 32'd0);
        tick();
        chk("dl_slrd_rise", 32'(fx3_slrd_n), 32'd1);
        chk("dl_drain_g1", 32'(dl_grant), 32'd1);
        dl_req = 1'b0;
        tick();
        chk("dl_drain_g2", 32'(dl_grant), 32'd1);
        tick();
        chk("dl_drain_end", 32'(dl_grant), 32'd0);

        // ---- upload across threads, full 512-byte packet
        ul_req = 1'b1; fx3_flaga = 1'b1;
        tick();
        chk("ul_a_switch", 32'(fx3_a), 32'd0);
        chk("ul_sw_nogrant", 32'(ul_grant), 32'd0);
        tick(); tick();
        chk("ul_sw_end_nogrant", 32'(ul_grant), 32'd0);
        tick();
        chk("ul_grant_on", 32'(ul_grant), 32'd1);
        chk("ul_ready_blank0", 32'(ul_ready), 32'd0);
        tick();
        chk("ul_ready_blank1", 32'(ul_ready), 32'd0);
        tick();
        chk("ul_ready_blank2", 32'(ul_ready), 32'd0);
        tick();
        chk("ul_ready_on", 32'(ul_ready), 32'd1);
        ul_send(512, nw, npe);
        ul_req = 1'b0;
        chk("ul_full_writes", 32'(nw), 32'd512);
        chk("ul_full_nopktend", 32'(npe), 32'd0);
        chk("ul_full_pktcnt", 32'(ul_pkt_cnt), 32'd1);
        rz = (ul_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!ul_ready) rz++;
        end
        chk("ul_commit_ready0", 32'(rz), 32'd4);
        chk("ul_commit_grant", 32'(ul_grant), 32'd1);
        tick();
        chk("ul_commit_idle", 32'(ul_grant), 32'd0);
        chk("ul_commit_pktcnt", 32'(ul_pkt_cnt), 32'd1);

        // ---- short packet: 100 bytes then ul_req drops
        ul_req = 1'b1;
        tick();
        chk("sp_no_switch", 32'({fx3_a, ul_grant}), 32'b001);
        ul_send(100, nw, npe);
        chk("sp_writes", 32'(nw), 32'd100);
        chk("sp_no_early_pktend", 32'(npe), 32'd0);
        ul_req = 1'b0;
        tick();
        chk("sp_pktend_low", 32'({fx3_pktend_n, fx3_slwr_n}), 32'b01);
        chk("sp_pktcnt", 32'(ul_pkt_cnt), 32'd2);
        chk("sp_ready_off", 32'(ul_ready), 32'd0);
        tick();
        chk("sp_pktend_1cyc", 32'(fx3_pktend_n), 32'd1);
        tick(); tick(); tick();
        chk("sp_idle", 32'(ul_grant), 32'd0);

        // ---- both requesting: DL, UL, DL with a switch before each change
        dl_avail = 1'b1; dl_reads = 0; nstart = 0; gap = 0; overlap = 0; prev_any = 1'b0;
        dl_req = 1'b1; ul_req = 1'b1;
        for (int c = 0; c < 3000 && nstart < 3; c++) begin
            fx3_flaga = (fx3_a == 2'b00) ? 1'b1 : dl_avail;
            ul_vld = ul_ready;
            tick();
            if (!fx3_slrd_n) begin
                dl_reads++;
                if (dl_reads >= 6) dl_avail = 1'b0;
            end
            if (ul_grant) begin
                dl_avail = 1'b1;
                dl_reads = 0;
            end
            if (dl_grant && ul_grant) overlap++;
            if ((dl_grant || ul_grant) && !prev_any) begin
                seq[nstart]  = {dl_grant, ul_grant};
                a_at[nstart] = fx3_a;
                gaps[nstart] = gap;
                nstart++;
            end
            gap = (dl_grant || ul_grant) ? 0 : gap + 1;
            prev_any = dl_grant || ul_grant;
        end
        ul_vld = 1'b0;
        chk("rr_starts", 32'(nstart), 32'd3);
        if (nstart == 3) begin
            chk("rr_seq0", 32'(seq[0]), 32'b10);
            chk("rr_seq1", 32'(seq[1]), 32'b01);
            chk("rr_seq2", 32'(seq[2]), 32'b10);
            chk("rr_a0", 32'(a_at[0]), 32'd3);
            chk("rr_a1", 32'(a_at[1]), 32'd0);
            chk("rr_a2", 32'(a_at[2]), 32'd3);
            chk("rr_gap0", 32'(gaps[0]), 32'd3);
            chk("rr_gap1", 32'(gaps[1]), 32'd4);
            chk("rr_gap2", 32'(gaps[2]), 32'd4);
        end
        chk("rr_overlap", 32'(overlap), 32'd0);
        chk("rr_pktcnt", 32'(ul_pkt_cnt), 32'd3);
        dl_req = 1'b0; ul_req = 1'b0; fx3_flaga = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rr_released", 32'({dl_grant, ul_grant}), 32'b00);

        // ---- flag stall after 200 bytes, then 312 more with no pktend
        ul_req = 1'b1;
        ul_send(200, nw, npe);
        chk("st_first200", 32'(nw), 32'd200);
        fx3_flaga = 1'b0;
        rz = 0; sw = 0;
        for (int i = 0; i < 10; i++) begin
            ul_vld = !ul_ready;
            tick();
            if (!ul_ready) rz++;
            if (!fx3_slwr_n) sw++;
        end
        ul_vld = 1'b0;
        chk("st_ready_low_cycles", 32'(rz), 32'd8);
        chk("st_no_strobes", 32'(sw), 32'd0);
        chk("st_still_granted", 32'(ul_grant), 32'd1);
        fx3_flaga = 1'b1;
        ul_send(312, nw2, npe2);
        chk("st_rest312", 32'(nw2), 32'd312);
        chk("st_nopktend", 32'(npe + npe2), 32'd0);
        chk("st_pktcnt", 32'(ul_pkt_cnt), 32'd4);
        chk("st_commit_ready", 32'(ul_ready), 32'd0);
        ul_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("st_idle", 32'(ul_grant), 32'd0);

        // ---- frame_rst_fx3 mid DL_BURST
        dl_req = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (!fx3_slrd_n) found = 1;
        end
        chk("fr_dl_active", 32'(found), 32'd1);
        frame_rst_fx3 = 1'b1;
        tick();
        frame_rst_fx3 = 1'b0;
        chk("fr_a", 32'(fx3_a), 32'd3);
        chk("fr_strobes", 32'({fx3_slrd_n, fx3_slwr_n, fx3_pktend_n}), 32'b111);
        chk("fr_grants", 32'({dl_grant, ul_grant, ul_ready}), 32'b000);
        chk("fr_pktcnt", 32'(ul_pkt_cnt), 32'd0);
        tick();
        chk("fr_from_idle", 32'({dl_grant, fx3_slrd_n}), 32'b11);

        // ---- asynchronous reset mid burst, checked before the next edge
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (!fx3_slrd_n) found = 1;
        end
        chk("ar_dl_active", 32'(found), 32'd1);
        #3;
        fx3_rst = 1'b1;
        #1;
        chk("ar_strobes", 32'({fx3_slrd_n, fx3_slwr_n, fx3_pktend_n}), 32'b111);
        chk("ar_grant", 32'(dl_grant), 32'd0);
        dl_req = 1'b0;
        tick();
        fx3_rst = 1'b0;
        tick();
        chk("ar_pktcnt", 32'(ul_pkt_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fx3_thread_arbiter.md
# fx3_thread_arbiter

Owns the FX3 slave-FIFO control plane: it shares the single 8-bit GPIF bus between the download requester (thread 3, FX3->FPGA image data) and the upload requester (thread 0, FPGA->FX3 results), and drives the address and strobes. It handles thread-switch settling, flag qualification, 512-byte packet boundaries with commit gaps, and short-packet end. The datapath (data registers, pixel packing, image FIFO) stays outside and acts only on the grant/strobe outputs.

## Interface
- PKT_BYTES, 512, FX3 buffer size in bytes; upload burst length
- SWITCH_DLY, 3, cycles after an fx3_a change before fx3_flaga is trusted
- FLAG_LAT, 2, register stages on fx3_flaga; also DL drain length
- COMMIT_GAP, 4, idle cycles after a full or short upload packet
- fx3_clk  in  1  FX3 interface clock; the only clock
- fx3_rst  in  1  asynchronous, active-high reset
- frame_rst_fx3  in  1  synchronous clear, same effect as reset, one cycle
- dl_req  in  1  download side wants data (buffer has room)
- ul_req  in  1  upload side holds data to send
- ul_vld  in  1  upload byte presented this cycle; legal only while ul_ready=1
- fx3_flaga  in  1  FX3 flag for the addressed thread (1 = data/space available)
- fx3_a  out  2  thread address: 2'b11 download, 2'b00 upload
- fx3_slrd_n  out  1  read strobe, active low
- fx3_slwr_n  out  1  write strobe, active low
- fx3_pktend_n  out  1  packet-end strobe, active low
- dl_grant  out  1  download owns the bus; capture data while asserted
- ul_grant  out  1  upload owns the bus
- ul_ready  out  1  upload may present a byte this cycle
- ul_pkt_cnt  out  16  completed upload packets, full and short; wraps

## Operation
- States: IDLE, SWITCH, DL_BURST, DL_DRAIN, UL_BURST, UL_COMMIT.
- Reset and frame_rst_fx3 values: state IDLE, fx3_a=2'b11, all three strobes 1, grants 0, ul_ready 0, byte count 0, ul_pkt_cnt 0, last-served = upload (download wins the first tie).
- flag_q is fx3_flaga delayed by FLAG_LAT registers. It is forced to 0 while in SWITCH and for the first FLAG_LAT cycles after SWITCH exits.
- IDLE: choose a requester. When only one requests, it wins. When both request, the one not served last wins (round-robin). If the winner's thread differs from fx3_a, drive the new fx3_a and go to SWITCH. Otherwise go straight to that requester's burst state.
- SWITCH: hold for SWITCH_DLY cycles, then go to the pending burst state. If the pending request drops during SWITCH, return to IDLE and leave fx3_a at its new value.
- DL_BURST: dl_grant=1. fx3_slrd_n=~(flag_q & dl_req). When flag_q=0 or dl_req=0, go to DL_DRAIN.
- DL_DRAIN: fx3_slrd_n=1 and dl_grant stays 1 for FLAG_LAT cycles so in-flight bytes are captured. Then go to IDLE and set last-served = download.
- UL_BURST: ul_grant=1. ul_ready=flag_q. fx3_slwr_n=~(ul_vld & ul_ready). A 9-bit byte counter (log2 PKT_BYTES bits) increments on each write.
  - Write at count PKT_BYTES-1: counter wraps to 0, then go to UL_COMMIT with no pktend.
  - ul_req=0 with count>0: pulse fx3_pktend_n low for one cycle, clear the count, go to UL_COMMIT.
  - ul_req=0 with count=0: go to IDLE with no pktend.
- UL_COMMIT: ul_ready=0 for COMMIT_GAP cycles. ul_pkt_cnt increments once on entry. Then go to IDLE and set last-served = upload.
- ul_vld while ul_ready=0 is ignored: no strobe and no count.
- flag_q drops mid-upload: ul_ready goes to 0 and the state stays in UL_BURST. The count is kept, and the burst resumes when the flag returns.

## Timing
- fx3_a, the strobes, grants and ul_ready are registered outputs with no combinational path from inputs. Exception: fx3_slwr_n follows ul_vld with one register of latency.
- Request to first strobe, same thread: 1 (IDLE) + FLAG_LAT cycles. Across threads: add 1 + SWITCH_DLY cycles.
- fx3_slrd_n rises exactly 1 cycle after flag_q or dl_req falls.
- The pktend pulse lasts exactly one cycle and is never asserted together with fx3_slwr_n low.
- Asynchronous reset mid-burst forces every strobe high in the same cycle. No packet count is produced.

## Test plan
- Reset, then dl_req=1 with flaga=1: fx3_a stays 2'b11, no SWITCH, slrd_n low after 3 cycles. Drop the flag: slrd_n high 1 cycle later, dl_grant held 2 more cycles.
- ul_req=1 from idle with fx3_a=2'b11: fx3_a becomes 2'b00, 3 SWITCH cycles, then ul_ready after the flag qualifies. 512 ul_vld pulses give 512 slwr_n lows, then 4 cycles ready=0 and ul_pkt_cnt=1.
- Upload 100 bytes then drop ul_req: one fx3_pktend_n pulse, count cleared, ul_pkt_cnt increments, back to IDLE.
- dl_req and ul_req held together: grants alternate DL, UL, DL, with a SWITCH before each change of grant.
- Flag drops after 200 upload bytes for 10 cycles: ul_ready=0, no strobes. After recovery, 312 more bytes complete the packet with no pktend.
- frame_rst_fx3 pulse mid-DL_BURST: next cycle state is IDLE, fx3_a=2'b11, all strobes high, counts zero.
